iddmm_row_mac: RTL

// - One IDDMM inner-loop row: computes R = A + x*Y over WORDS 128-bit words, emitting WORDS+1 words LSW-first.
// - x is one scalar word; Y and A are multi-word operands held in an external word RAM.
// - Drives Y words into the iddmm_mul_128_to_256 pipeline and consumes its 256-bit products.
// - Adds each product to the matching A word and a running carry.

---
 rtl/iddmm_pkg.sv | 20 ++
 rtl/iddmm_row_mac_if.sv | 44 ++++
 rtl/iddmm_mul_128_to_256.sv | 29 ++
 rtl/iddmm_row_mac.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/iddmm_pkg.sv
// Shared types for the IDDMM row datapath.
//   WORD_W  : operand word width (128 bits)
//   word_t  : one operand word
//   dword_t : one double-width product / sum
//   state_t : row sequencer states
package iddmm_pkg;

  localparam int WORD_W = 128;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [2*WORD_W-1:0] dword_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/iddmm_row_mac_if.sv
// Row bus between a host/word RAM (master) and the row MAC (slave).
//   start, x_word        : row request and its scalar word
//   busy                 : row in progress
//   rd_en, rd_addr       : word read strobe and index
//   rd_y, rd_a           : Y[j] and A[j] returned by the RAM
//   out_valid, out_idx,
//   out_word, done       : result word stream
//
// Handshake rules:
//   - start is a one-cycle request. It is taken only while busy is low.
//     A start seen while busy is high has no effect.
//   - rd_en/rd_addr is fire-and-forget. The master must present rd_y and
//     rd_a exactly one cycle after each rd_en. There is no stall.
//   - out_valid is a push-only beat with no ready. One row yields
//     WORDS+1 back-to-back beats, and done marks the last one.
interface iddmm_row_mac_if #(
  parameter int WORDS = 32,
  parameter int AW    = $clog2(WORDS)
) ();
  import iddmm_pkg::*;

  logic          start;
  word_t         x_word;
  logic          busy;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  word_t         rd_y;
  word_t         rd_a;
  logic          out_valid;
  logic [AW:0]   out_idx;
  word_t         out_word;
  logic          done;

  modport master (
    output start, x_word, rd_y, rd_a,
    input  busy, rd_en, rd_addr, out_valid, out_idx, out_word, done
  );

  modport slave (
    input  start, x_word, rd_y, rd_a,
    output busy, rd_en, rd_addr, out_valid, out_idx, out_word, done
  );

endinterface

// File: rtl/iddmm_mul_128_to_256.sv
// Pipelined 128x128 -> 256-bit unsigned multiplier.
//   clk : clock
//   x_i : multiplicand
//   y_i : multiplier
//   p_o : product, LAT cycles after x_i/y_i are presented
// The pipeline carries no valid bit. Callers track valids alongside it.
module iddmm_mul_128_to_256
  import iddmm_pkg::*;
#(
  parameter int LAT = 7
) (
  input  logic   clk,
  input  word_t  x_i,
  input  word_t  y_i,
  output dword_t p_o
);

  dword_t p_q [LAT];

  always_ff @(posedge clk) begin
    p_q[0] <= dword_t'(x_i) * dword_t'(y_i);
    for (int k = 1; k < LAT; k++) begin
      p_q[k] <= p_q[k-1];
    end
  end

  assign p_o = p_q[LAT-1];

endmodule

// File: rtl/iddmm_row_mac.sv
// One IDDMM inner-loop row: R = A + x*Y over WORDS words.
// The row produces WORDS+1 result words, least significant word first.
//   clk, rst    : clock and synchronous active-high reset
//   bus         : row bus (slave side)
//   dbg_state_o : current sequencer state
//
// Row timeline, with start in cycle S:
//   - Y[j]/A[j] are read in cycle S+1+j.
//   - R[j] leaves in cycle S+1+j+MUL_LAT+2.
//   - The final carry leaves as word WORDS, one cycle after R[WORDS-1],
//     together with done.
// WORDS must be at least 2 and MUL_LAT at least 1.
module iddmm_row_mac
  import iddmm_pkg::*;
#(
  parameter int WORDS   = 32,
  parameter int MUL_LAT = 7,
  parameter int AW      = $clog2(WORDS)
) (
  input  logic           clk,
  input  logic           rst,
  iddmm_row_mac_if.slave bus,
  output state_t         dbg_state_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS-1);
  localparam logic [AW:0]   LAST_IDX  = (AW+1)'(WORDS-1);
  localparam logic [AW:0]   CARRY_IDX = (AW+1)'(WORDS);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  word_t         x_q;
  logic          rd_en;
  logic          start_acc;

  // The read valid is delayed by one cycle to line up with the RAM data.
  // It then rides next to A[j] for MUL_LAT cycles, matching the multiplier.
  logic               rd_vld_q;
  logic [MUL_LAT-1:0] v_dly_q;
  word_t              a_dly_q [MUL_LAT];

  dword_t        prod;
  dword_t        sum;
  logic          acc_fire;
  logic [AW-1:0] acc_cnt_q, acc_cnt_d;
  word_t         carry_q, carry_d;

  logic          out_valid_q, out_valid_d;
  logic [AW:0]   out_idx_q, out_idx_d;
  word_t         out_word_q, out_word_d;
  logic          done_q, done_d;
  logic          last_registered;

  assign start_acc = (state_q == ST_IDLE) && bus.start;

  // True in the cycle where R[WORDS-1] sits in the output register.
  // The carry beat follows in the next cycle.
  assign last_registered = out_valid_q && !done_q && (out_idx_q == LAST_IDX);

  // ---------------- sequencer ----------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ISSUE;
          addr_d  = '0;
        end
      end
      ST_ISSUE: begin
        rd_en = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = ST_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (last_registered) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (start_acc) begin
        x_q <= bus.x_word;
      end
    end
  end

  // ---------------- multiplier and A delay line ----------------
  iddmm_mul_128_to_256 #(.LAT(MUL_LAT)) u_mul (
    .clk (clk),
    .x_i (x_q),
    .y_i (bus.rd_y),
    .p_o (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      v_dly_q  <= '0;
    end else begin
      rd_vld_q   <= rd_en;
      v_dly_q[0] <= rd_vld_q;
      for (int k = 1; k < MUL_LAT; k++) begin
        v_dly_q[k] <= v_dly_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    a_dly_q[0] <= bus.rd_a;
    for (int k = 1; k < MUL_LAT; k++) begin
      a_dly_q[k] <= a_dly_q[k-1];
    end
  end

  // ---------------- accumulator and output register ----------------
  // The sum is at most (2^128-1)^2 + 2*(2^128-1) = 2^256-1.
  // So the upper half always fits in the carry word.
  assign acc_fire = v_dly_q[MUL_LAT-1];
  assign sum      = prod + dword_t'(a_dly_q[MUL_LAT-1]) + dword_t'(carry_q);

  always_comb begin
    carry_d     = carry_q;
    acc_cnt_d   = acc_cnt_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    out_idx_d   = out_idx_q;
    out_word_d  = out_word_q;
    if (start_acc) begin
      carry_d   = '0;
      acc_cnt_d = '0;
    end
    if (acc_fire) begin
      out_valid_d = 1'b1;
      out_idx_d   = {1'b0, acc_cnt_q};
      out_word_d  = sum[WORD_W-1:0];
      carry_d     = sum[2*WORD_W-1:WORD_W];
      acc_cnt_d   = acc_cnt_q + 1'b1;
    end else if ((state_q == ST_DRAIN) && last_registered) begin
      out_valid_d = 1'b1;
      out_idx_d   = CARRY_IDX;
      out_word_d  = carry_q;
      done_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q     <= '0;
      acc_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_word_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      carry_q     <= carry_d;
      acc_cnt_q   <= acc_cnt_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_word_q  <= out_word_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_word  = out_word_q;
  assign bus.done      = done_q;
  assign dbg_state_o   = state_q;

endmodule
